mem_stage_responder: RTL and testbench

Memory-side responder for the pipeline's MEM-stage data port. Accepts one read or write request at a time from the MEM stage over a request/ready handshake, applies a programmable number of wait states, services the access against an internal word-addressed storage array, and returns read data with a one-cycle `ready` pulse. It replaces the zero-latency BRAM path so that stall logic upstream can be exercised against a slow memory.

---
 rtl/mem_stage_responder.sv | 117 +++++++++++
 tb/tb_mem_stage_responder.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/mem_stage_responder.sv
// mem_stage_responder
// Slow memory model for the MEM-stage data port. One access at a time is
// accepted from IDLE, held for WAIT_STATES extra cycles, performed against an
// internal word-addressed array, and acknowledged with a one-cycle ready pulse.
//
// Ports:
//   clock             rising-edge clock
//   reset             asynchronous active-low reset
//   request           access request, held by the requester until ready
//   shouldWriteMemory 1 = write, 0 = read (sampled with request)
//   address           word address (sampled with request)
//   writeData         write data (sampled with request)
//   readData          last read result, registered
//   ready             one-cycle completion pulse
//   busy              transaction in flight (WAIT or RESPOND)
//   debug_state       current FSM state encoding (0 IDLE, 1 WAIT, 2 RESPOND)
//
// Handshake: the requester raises request with its command fields and keeps it
// high until it sees ready. The command is captured only on an edge where the
// responder is IDLE; every later change of the inputs is ignored until the
// transaction retires. A request still high after ready is treated as a new
// transaction and is taken on the edge after the RESPOND->IDLE edge.
module mem_stage_responder #(
  parameter int ADDR_WIDTH  = 8,
  parameter int WAIT_STATES = 2
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  request,
  input  logic                  shouldWriteMemory,
  input  logic [ADDR_WIDTH-1:0] address,
  input  logic [31:0]           writeData,
  output logic [31:0]           readData,
  output logic                  ready,
  output logic                  busy,
  output logic [1:0]            debug_state
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;
  localparam logic [3:0] WAIT_LOAD = 4'(WAIT_STATES);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_WAIT    = 2'd1,
    S_RESPOND = 2'd2
  } state_t;

  state_t                  state;
  logic [3:0]              wait_count;
  logic                    lat_write;
  logic [ADDR_WIDTH-1:0]   lat_addr;
  logic [31:0]             lat_data;
  logic [31:0]             storage [DEPTH];

  // The access fires on the WAIT->RESPOND edge only.
  logic do_access;
  assign do_access   = (state == S_WAIT) && (wait_count == 4'd0);
  assign debug_state = state;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state      <= S_IDLE;
      wait_count <= 4'd0;
      lat_write  <= 1'b0;
      lat_addr   <= '0;
      lat_data   <= 32'd0;
      readData   <= 32'd0;
      ready      <= 1'b0;
      busy       <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          ready <= 1'b0;
          if (request) begin
            lat_write  <= shouldWriteMemory;
            lat_addr   <= address;
            lat_data   <= writeData;
            wait_count <= WAIT_LOAD;
            busy       <= 1'b1;
            state      <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (wait_count == 4'd0) begin
            if (!lat_write) begin
              readData <= storage[lat_addr];
            end
            ready <= 1'b1;
            state <= S_RESPOND;
          end else begin
            // Only decremented while nonzero, so the counter never wraps.
            wait_count <= wait_count - 4'd1;
          end
        end
        S_RESPOND: begin
          ready <= 1'b0;
          busy  <= 1'b0;
          state <= S_IDLE;
        end
        default: begin
          ready <= 1'b0;
          busy  <= 1'b0;
          state <= S_IDLE;
        end
      endcase
    end
  end

  // Storage is not reset. While reset is held the FSM sits in IDLE, so a
  // write that had not yet reached its access edge is dropped.
  always_ff @(posedge clock) begin
    if (do_access && lat_write) begin
      storage[lat_addr] <= lat_data;
    end
  end

endmodule

// File: tb/tb_mem_stage_responder.sv
// tb_mem_stage_responder
// Two responders share clock and reset: instance 0 with WAIT_STATES=2 and
// instance 1 with WAIT_STATES=0. Read results are predicted from a bench-side
// memory model and queued when a read is driven, then popped and compared in
// the ready cycle.
module tb_mem_stage_responder;

  logic        clock;
  logic        reset;
  logic        req   [2];
  logic        we    [2];
  logic [7:0]  addr  [2];
  logic [31:0] wdata [2];
  logic [31:0] rdata [2];
  logic        rdy   [2];
  logic        bsy   [2];
  logic [1:0]  st    [2];

  logic [31:0] model_mem [2][256];
  logic        written   [2][256];
  logic [31:0] last_rd   [2];
  logic [31:0] exp_q[$];

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;

  // ---------------- clock / reset ----------------
  initial clock = 1'b0;
  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  mem_stage_responder #(.ADDR_WIDTH(8), .WAIT_STATES(2)) dut_ws2 (
    .clock(clock), .reset(reset), .request(req[0]), .shouldWriteMemory(we[0]),
    .address(addr[0]), .writeData(wdata[0]), .readData(rdata[0]),
    .ready(rdy[0]), .busy(bsy[0]), .debug_state(st[0])
  );

  mem_stage_responder #(.ADDR_WIDTH(8), .WAIT_STATES(0)) dut_ws0 (
    .clock(clock), .reset(reset), .request(req[1]), .shouldWriteMemory(we[1]),
    .address(addr[1]), .writeData(wdata[1]), .readData(rdata[1]),
    .ready(rdy[1]), .busy(bsy[1]), .debug_state(st[1])
  );

  function automatic int ws(input int i);
    return (i == 0) ? 2 : 0;
  endfunction

  // ---------------- checker ----------------
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", tag, got, exp, $time);
  endtask

  // ---------------- driver tasks ----------------
  // Called at a negedge: present the command; reads push their expectation.
  task automatic start_access(input int i, input logic w, input logic [7:0] a,
                              input logic [31:0] d);
    req[i]   = 1'b1;
    we[i]    = w;
    addr[i]  = a;
    wdata[i] = d;
    if (!w) exp_q.push_back(model_mem[i][a]);
  endtask

  // Sampling edge onward: verify busy, latency, data and the return to idle.
  task automatic finish_access(input int i, input logic w, input logic [7:0] a,
                               input logic [31:0] d, input bit churn);
    int cnt;
    bit got;
    @(posedge clock);
    @(negedge clock);
    check($sformatf("busy_after_accept%0d", i), 32'(bsy[i]), 32'd1);
    cnt = 0;
    got = 1'b0;
    while (!got && cnt < 40) begin
      if (churn) begin
        addr[i]  = 8'($urandom_range(0, 255));
        wdata[i] = $urandom;
      end
      @(posedge clock);
      cnt++;
      @(negedge clock);
      got = rdy[i];
    end
    check($sformatf("ready_latency%0d", i), 32'(cnt), 32'(ws(i) + 1));
    if (w) begin
      check($sformatf("rdata_hold_on_write%0d", i), rdata[i], last_rd[i]);
      model_mem[i][a] = d;
      written[i][a]   = 1'b1;
    end else if (exp_q.size() > 0) begin
      check($sformatf("rdata%0d_a%02h", i, a), rdata[i], exp_q.pop_front());
      last_rd[i] = rdata[i];
    end else begin
      check("exp_q_underflow", 32'd1, 32'd0);
    end
    req[i] = 1'b0;
    @(posedge clock);
    @(negedge clock);
    check($sformatf("ready_pulse_end%0d", i), 32'(rdy[i]), 32'd0);
    check($sformatf("busy_release%0d", i), 32'(bsy[i]), 32'd0);
  endtask

  task automatic do_access(input int i, input logic w, input logic [7:0] a,
                           input logic [31:0] d, input bit churn);
    start_access(i, w, a, d);
    finish_access(i, w, a, d, churn);
  endtask

  // request held high across three reads of addresses 0,1,2 on instance 0
  task automatic back_to_back_reads();
    int cnt;
    int prev;
    bit got;
    req[0]  = 1'b1;
    we[0]   = 1'b0;
    addr[0] = 8'd0;
    for (int k = 0; k < 3; k++) exp_q.push_back(model_mem[0][k]);
    prev = 0;
    for (int k = 0; k < 3; k++) begin
      cnt = 0;
      got = 1'b0;
      while (!got && cnt < 40) begin
        @(posedge clock);
        cnt++;
        @(negedge clock);
        got = rdy[0];
      end
      check("b2b_ready_seen", 32'(got), 32'd1);
      if (k > 0) check("b2b_spacing", 32'(cyc - prev), 32'(ws(0) + 3));
      prev = cyc;
      if (exp_q.size() > 0) check($sformatf("b2b_data%0d", k), rdata[0], exp_q.pop_front());
      else check("exp_q_underflow", 32'd1, 32'd0);
      last_rd[0] = rdata[0];
      addr[0] = 8'(k + 1);
    end
    req[0] = 1'b0;
    @(posedge clock);
    @(negedge clock);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int a;
    for (int i = 0; i < 2; i++) begin
      req[i] = 1'b0; we[i] = 1'b0; addr[i] = 8'd0; wdata[i] = 32'd0;
      last_rd[i] = 32'd0;
      for (int j = 0; j < 256; j++) begin
        model_mem[i][j] = 32'd0;
        written[i][j]   = 1'b0;
      end
    end

    // Reset held with a pending request on instance 0.
    reset = 1'b0;
    start_access(0, 1'b1, 8'h10, 32'hDEADBEEF);
    repeat (3) @(posedge clock);
    @(negedge clock);
    for (int i = 0; i < 2; i++) begin
      check($sformatf("reset_ready%0d", i), 32'(rdy[i]), 32'd0);
      check($sformatf("reset_busy%0d", i), 32'(bsy[i]), 32'd0);
      check($sformatf("reset_rdata%0d", i), rdata[i], 32'd0);
      check($sformatf("reset_state%0d", i), 32'(st[i]), 32'd0);
    end
    reset = 1'b1;
    // The held request is accepted on the first edge after release.
    finish_access(0, 1'b1, 8'h10, 32'hDEADBEEF, 1'b0);
    do_access(0, 1'b0, 8'h10, 32'h0, 1'b0);

    // Zero wait states, top address.
    do_access(1, 1'b1, 8'hFF, 32'h12345678, 1'b0);
    do_access(1, 1'b0, 8'hFF, 32'h0, 1'b0);
    do_access(1, 1'b1, 8'h00, 32'h0BADF00D, 1'b0);
    do_access(1, 1'b0, 8'h00, 32'h0, 1'b0);
    do_access(1, 1'b0, 8'hFF, 32'h0, 1'b0);

    // Held request back-to-back.
    do_access(0, 1'b1, 8'd0, 32'hA, 1'b0);
    do_access(0, 1'b1, 8'd1, 32'hB, 1'b0);
    do_access(0, 1'b1, 8'd2, 32'hC, 1'b0);
    back_to_back_reads();

    // Input churn while waiting.
    do_access(0, 1'b1, 8'h33, 32'hCAFEF00D, 1'b1);
    do_access(0, 1'b0, 8'h33, 32'h0, 1'b1);
    do_access(0, 1'b0, 8'h10, 32'h0, 1'b1);

    // Random traffic; reads only target words already written.
    for (int n = 0; n < 24; n++) begin
      int i;
      i = n % 2;
      a = $urandom_range(0, 255);
      if (written[i][a] && $urandom_range(0, 1) == 1)
        do_access(i, 1'b0, 8'(a), 32'h0, 1'b0);
      else
        do_access(i, 1'b1, 8'(a), $urandom, 1'b0);
    end

    // Reset in the middle of a write: storage must keep the old word.
    do_access(0, 1'b1, 8'h20, 32'h77, 1'b0);
    start_access(0, 1'b1, 8'h20, 32'h55);
    @(posedge clock);
    @(negedge clock);
    check("midreset_busy_before", 32'(bsy[0]), 32'd1);
    reset = 1'b0;
    #1;
    check("midreset_ready", 32'(rdy[0]), 32'd0);
    check("midreset_busy", 32'(bsy[0]), 32'd0);
    check("midreset_rdata", rdata[0], 32'd0);
    last_rd[0] = 32'd0;
    last_rd[1] = 32'd0;
    req[0] = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(posedge clock);
      @(negedge clock);
      check("midreset_no_ready", 32'(rdy[0]), 32'd0);
    end
    reset = 1'b1;
    @(posedge clock);
    @(negedge clock);
    do_access(0, 1'b0, 8'h20, 32'h0, 1'b0);
    do_access(1, 1'b0, 8'hFF, 32'h0, 1'b0);

    check("exp_q_drained", 32'(exp_q.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  // Global time limit so a stuck run still reports.
  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    $display("%0d/%0d checks passed", n_pass, n_checks + 1);
    $fatal(1);
  end

endmodule
